serl_parll_pack: RTL and testbench
==================================

Name: serl_parll_pack

Overview:
Byte-serial to 32-bit word packer with a small word FIFO. It sits directly downstream of the 8-bit AES datapath output and upstream of the AHB read-data path. It collects four bytes most-significant-byte first and buffers the assembled words for the bus side. It is the inverse of the word-to-byte unloader on the input side of the datapath, and uses the same byte order.

Parameters:
DEPTH, 4, number of 32-bit word entries in the output FIFO; must be a power of 2 and at least 2.
CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-high; clears all state immediately.
flush  input  1  synchronous clear of the partial word and the FIFO.
din_vld  input  1  byte valid from the datapath.
din  input  8  byte data.
din_rdy  output  1  packer can accept a byte this cycle.
dout_vld  output  1  FIFO head word is valid.
dout  output  32  FIFO head word (first-word-fall-through).
dout_rdy  input  1  consumer takes the head word this cycle.
byte_cnt  output  2  number of bytes held in the partial word (0-3).
count  output  CW  number of complete words in the FIFO (0..DEPTH).
full  output  1  count == DEPTH.
empty  output  1  count == 0.

Behaviour:
- Reset (asynchronous, rst=1):
  - byte_cnt=0, count=0, read and write pointers=0, assembly register=0.
  - Outputs: din_rdy=1, dout_vld=0, dout=32'h0, full=0, empty=1.
  - Memory contents are not reset.
- Byte accept: a byte is accepted when din_vld && din_rdy at a rising edge.
  - byte_cnt 0 writes asm[31:24]; 1 writes asm[23:16]; 2 writes asm[15:8].
  - byte_cnt 3: the word {asm[31:8], din} is written to the FIFO on that same edge, and byte_cnt wraps to 0.
- din_rdy = !(byte_cnt==3 && full).
  - Bytes 0-2 are accepted even when the FIFO is full.
  - din_rdy depends only on registered state. There is no combinational path from dout_rdy to din_rdy.
- Pop: occurs when dout_vld && dout_rdy.
  - dout_vld = !empty.
  - dout = mem[rd_ptr] when not empty, 32'h0 when empty.
- Pointers wrap modulo DEPTH. count increments on push-only, decrements on pop-only, and is unchanged when push and pop happen together.
- Latency: a word written by the 4th byte at edge N is visible on dout with dout_vld=1 after edge N, i.e. in the cycle following acceptance, when the FIFO was empty.
- Full with pop and a pending 4th byte: din_rdy is 0 that cycle, so no push occurs. After the pop, count=DEPTH-1 and din_rdy rises the next cycle.
- Empty with dout_rdy=1: no pop; count stays at 0.
- dout_vld, once asserted, holds with a stable dout until a pop.
- Flush (synchronous):
  - Clears byte_cnt, count and both pointers.
  - Discards the partial word.
  - Takes priority over byte accept and pop in the same cycle; that byte and that pop are dropped.
- Reset mid-word or mid-transfer: all state is lost immediately; there is no partial recovery.
- Invariant: full and empty are never both 1.

Test Plan:
1. Stream 00..0F with din_vld=1 and dout_rdy=1 from empty.
   - Required: words 00010203, 04050607, 08090A0B, 0C0D0E0F in order.
   - Each word appears with dout_vld=1 one cycle after its 4th byte; din_rdy stays 1 throughout.
2. dout_rdy=0, stream 20 bytes 10..23 with DEPTH=4.
   - Required: count reaches 4 and full=1 after the 16th byte.
   - Bytes 20,21,22 are accepted (byte_cnt=3); din_rdy=0 while the 20th byte 23 is held.
   - With dout_rdy=1 for one cycle: pop 10111213, din_rdy=1 the next cycle, then 23 is accepted.
   - Draining then yields 14151617, 18191A1B, 1C1D1E1F, 20212223.
3. FIFO holding 2 words, 4th byte accepted in the same cycle as a pop.
   - Required: count stays 2, the head advances, and word order is preserved.
4. Feed AA, BB, then assert flush in the same cycle as byte CC and a pop.
   - Required: next cycle byte_cnt=0, count=0, dout_vld=0, dout=0.
   - Following bytes 01,02,03,04 produce 01020304.
5. Assert rst asynchronously mid-cycle with byte_cnt=2 and count=3.
   - Required: before the next clock edge, outputs read dout_vld=0, dout=0, empty=1, din_rdy=1, byte_cnt=0.
6. dout_rdy=1 while empty for 5 cycles, then one word is pushed.
   - Required: count never underflows and dout_vld rises exactly once.

Source files
------------

// File: rtl/serl_parll_pack_if.sv
// Byte-in / word-out handshake bundle for the serial-to-parallel packer.
// The master modport is the environment side; the slave modport is the packer.
interface serl_parll_pack_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          din_vld;
  logic [7:0]    din;
  logic          din_rdy;
  logic          dout_vld;
  logic [31:0]   dout;
  logic          dout_rdy;
  logic [1:0]    byte_cnt;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output flush, din_vld, din, dout_rdy,
    input  din_rdy, dout_vld, dout, byte_cnt, count, full, empty
  );

  modport slave (
    input  flush, din_vld, din, dout_rdy,
    output din_rdy, dout_vld, dout, byte_cnt, count, full, empty
  );
endinterface

// File: rtl/serl_parll_pack.sv
// Packs bytes MSB-first into 32-bit words and buffers them in a
// first-word-fall-through FIFO of DEPTH entries.
module serl_parll_pack #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serl_parll_pack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [23:0]   asm_q;        // holds asm[31:8]; the 4th byte goes straight to the FIFO
  logic [1:0]    byte_cnt_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic full_w, empty_w, rdy_w, accept, push, pop;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  // Only the 4th byte needs FIFO space, so earlier bytes keep flowing when full.
  assign rdy_w   = !((byte_cnt_q == 2'd3) && full_w);
  assign accept  = bus.din_vld && rdy_w && !bus.flush;
  assign push    = accept && (byte_cnt_q == 2'd3);
  assign pop     = !empty_w && bus.dout_rdy && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q      <= '0;
      byte_cnt_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
    end else if (bus.flush) begin
      asm_q      <= '0;
      byte_cnt_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
    end else begin
      if (accept) begin
        unique case (byte_cnt_q)
          2'd0:    asm_q[23:16] <= bus.din;
          2'd1:    asm_q[15:8]  <= bus.din;
          2'd2:    asm_q[7:0]   <= bus.din;
          default: ;
        endcase
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {asm_q, bus.din};
  end

  assign bus.din_rdy  = rdy_w;
  assign bus.dout_vld = !empty_w;
  assign bus.dout     = empty_w ? '0 : mem[rd_ptr];
  assign bus.byte_cnt = byte_cnt_q;
  assign bus.count    = count_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
endmodule

// File: tb/tb_serl_parll_pack.sv
// Bench for serl_parll_pack: vector table, directed corner sequences and a
// randomized phase checked against a queue-based reference model.
module tb_serl_parll_pack;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  serl_parll_pack_if #(.DEPTH(DEPTH)) bus ();

  serl_parll_pack #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending bytes of the current word and the word FIFO.
  logic [7:0]  m_part [$];
  logic [31:0] m_fifo [$];

  function automatic logic m_rdy();
    return !(m_part.size() == 3 && m_fifo.size() == DEPTH);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_edge();
    logic rdy, vld;
    rdy = m_rdy();
    vld = (m_fifo.size() != 0);
    if (rst || bus.flush) begin
      m_part.delete();
      m_fifo.delete();
    end else begin
      if (vld && bus.dout_rdy) void'(m_fifo.pop_front());
      if (bus.din_vld && rdy) begin
        m_part.push_back(bus.din);
        if (m_part.size() == 4) begin
          m_fifo.push_back({m_part[0], m_part[1], m_part[2], m_part[3]});
          m_part.delete();
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [63:0] act, exp;
    logic [31:0] hd;
    int unsigned nw;
    nw  = m_fifo.size();
    hd  = (nw != 0) ? m_fifo[0] : 32'h0;
    exp = {23'h0, m_rdy(), (nw != 0), (nw == DEPTH), (nw == 0),
           2'(m_part.size()), 3'(nw), hd};
    act = {23'h0, bus.din_rdy, bus.dout_vld, bus.full, bus.empty,
           bus.byte_cnt, bus.count, bus.dout};
    check(name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model("model");
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    bus.din_vld  = 1'b1;
    bus.din      = b;
    bus.dout_rdy = rdy;
    tick();
  endtask

  typedef struct {
    logic        flush;
    logic        vld;
    logic [7:0]  din;
    logic        rdy;
    logic        e_rdy;
    logic        e_vld;
    logic [1:0]  e_bc;
    logic [2:0]  e_cnt;
    logic [31:0] e_dout;
  } vec_t;

  vec_t tv [$];

  task automatic addv(input logic fl, input logic v, input logic [7:0] d, input logic r,
                      input logic e_vld, input logic [1:0] e_bc, input logic [2:0] e_cnt,
                      input logic [31:0] e_dout);
    vec_t t;
    t.flush = fl; t.vld = v; t.din = d; t.rdy = r;
    t.e_rdy = 1'b1; t.e_vld = e_vld; t.e_bc = e_bc; t.e_cnt = e_cnt; t.e_dout = e_dout;
    tv.push_back(t);
  endtask

  initial begin
    logic [31:0] drain_exp [4];
    logic [7:0]  b;
    logic        prev_vld;
    int          rises;

    // Stream 00..0F with dout_rdy=1: each word shows one cycle after its 4th byte.
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      if (i % 4 == 3)
        addv(1'b0, 1'b1, b, 1'b1, 1'b1, 2'd0, 3'd1, {b - 8'd3, b - 8'd2, b - 8'd1, b});
      else
        addv(1'b0, 1'b1, b, 1'b1, 1'b0, 2'((i + 1) % 4), 3'd0, 32'h0);
    end
    // AA, BB with 0C0D0E0F still queued, then flush together with CC and a pop.
    addv(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 2'd1, 3'd1, 32'h0C0D0E0F);
    addv(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1, 2'd2, 3'd1, 32'h0C0D0E0F);
    addv(1'b1, 1'b1, 8'hCC, 1'b1, 1'b0, 2'd0, 3'd0, 32'h0);
    addv(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 2'd1, 3'd0, 32'h0);
    addv(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 2'd2, 3'd0, 32'h0);
    addv(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 2'd3, 3'd0, 32'h0);
    addv(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 2'd0, 3'd1, 32'h01020304);
    addv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd0, 32'h0);

    // Reset state
    rst = 1'b1;
    bus.flush = 1'b0; bus.din_vld = 1'b0; bus.din = 8'h0; bus.dout_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'({bus.din_rdy, bus.dout_vld, bus.full, bus.empty, bus.byte_cnt, bus.count, bus.dout}),
          64'({1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0}));
    rst = 1'b0;

    // Vector table
    foreach (tv[i]) begin
      bus.flush = tv[i].flush; bus.din_vld = tv[i].vld; bus.din = tv[i].din; bus.dout_rdy = tv[i].rdy;
      tick();
      check($sformatf("vec%0d", i),
            64'({bus.din_rdy, bus.dout_vld, bus.byte_cnt, bus.count, bus.dout}),
            64'({tv[i].e_rdy, tv[i].e_vld, tv[i].e_bc, tv[i].e_cnt, tv[i].e_dout}));
    end
    bus.flush = 1'b0; bus.din_vld = 1'b0; bus.dout_rdy = 1'b0;

    // Fill to full, hold the 4th byte of the 5th word, single pop releases it.
    for (int i = 16; i < 32; i++) send_byte(8'(i), 1'b0);
    check("full_cnt", 64'({bus.full, bus.count}), 64'({1'b1, 3'd4}));
    for (int i = 32; i < 35; i++) send_byte(8'(i), 1'b0);
    check("bc3_full", 64'(bus.byte_cnt), 64'd3);
    bus.din = 8'h23;
    #0;
    check("rdy_low", 64'(bus.din_rdy), 64'd0);
    tick();
    check("held", 64'({bus.din_rdy, bus.byte_cnt, bus.count}), 64'({1'b0, 2'd3, 3'd4}));
    check("head_before_pop", 64'(bus.dout), 64'h10111213);
    bus.dout_rdy = 1'b1;
    tick();
    check("after_pop", 64'({bus.din_rdy, bus.count, bus.dout}), 64'({1'b1, 3'd3, 32'h14151617}));
    bus.dout_rdy = 1'b0;
    tick();
    check("accept_23", 64'({bus.byte_cnt, bus.count}), 64'({2'd0, 3'd4}));
    bus.din_vld = 1'b0;
    drain_exp = '{32'h14151617, 32'h18191A1B, 32'h1C1D1E1F, 32'h20212223};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), 64'({bus.dout_vld, bus.dout}), 64'({1'b1, drain_exp[k]}));
      bus.dout_rdy = 1'b1;
      tick();
    end
    check("drained", 64'(bus.empty), 64'd1);

    // Push and pop on the same edge with two words queued.
    for (int i = 0; i < 11; i++) send_byte(8'h30 + 8'(i), 1'b0);
    send_byte(8'h3B, 1'b1);
    check("pushpop", 64'({bus.count, bus.dout}), 64'({3'd2, 32'h34353637}));
    bus.din_vld = 1'b0;
    tick();
    check("pushpop_order", 64'(bus.dout), 64'h38393A3B);
    tick();
    bus.dout_rdy = 1'b0;

    // Pop requests while empty, then a single word.
    bus.dout_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("empty_pop%0d", k), 64'({bus.dout_vld, bus.count}), 64'd0);
    end
    rises = 0;
    prev_vld = bus.dout_vld;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) send_byte(8'h40 + 8'(k), 1'b1);
      else begin
        bus.din_vld = 1'b0;
        tick();
      end
      if (bus.dout_vld && !prev_vld) rises++;
      prev_vld = bus.dout_vld;
    end
    check("vld_rises", 64'(rises), 64'd1);
    bus.dout_rdy = 1'b0;

    // Asynchronous reset with byte_cnt=2, count=3.
    for (int i = 0; i < 14; i++) send_byte(8'h50 + 8'(i), 1'b0);
    bus.din_vld = 1'b0;
    check("pre_rst", 64'({bus.byte_cnt, bus.count}), 64'({2'd2, 3'd3}));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 64'({bus.dout_vld, bus.dout, bus.empty, bus.din_rdy, bus.byte_cnt}),
          64'({1'b0, 32'h0, 1'b1, 1'b1, 2'd0}));
    m_part.delete();
    m_fifo.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model("post_rst");

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      bus.din_vld  = 1'($urandom_range(0, 3) != 0);
      bus.din      = 8'($urandom);
      bus.dout_rdy = 1'($urandom_range(0, 2) == 0);
      bus.flush    = 1'($urandom_range(0, 47) == 0);
      tick();
      if (bus.full && bus.empty) check("full_empty", 64'd1, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
